root_req_sched: RTL and testbench

Request scheduler sitting directly upstream of the iterative root core. It accepts (radicand, degree, tag) requests on a valid/ready stream, buffers them, and drives the core's single-shot `in_valid` protocol one request at a time. It captures the core's Q10.10 result and returns it with its tag on a valid/ready response stream. It shields callers from the core's hold-stable and turnaround requirements.

---
 rtl/root_pkg.sv | 19 +
 rtl/root_req_fifo.sv | 48 ++++
 rtl/root_req_sched.sv | 172 +++++++++++++++++
 tb/tb_root_req_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/root_pkg.sv
// Shared definitions for the root request scheduler: FSM states, operand
// widths, Q10.10 constants and the core input-valid hold length.
package root_pkg;
  localparam int RAD_W    = 10;
  localparam int DEG_W    = 3;
  localparam int Q_W      = 20;
  localparam int FRAC_W   = Q_W - RAD_W;
  localparam int HOLD_CNT = 2;
  localparam int HC_W     = $clog2(HOLD_CNT + 1);

  localparam logic [Q_W-1:0] Q_ONE = 20'h00400;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} sched_st_t;

  typedef struct packed {
    logic [RAD_W-1:0] rad;
    logic [DEG_W-1:0] deg;
  } op_t;
endpackage

// File: rtl/root_req_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty derive from it.
module root_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/root_req_sched.sv
// Request scheduler in front of the iterative root core. Buffers requests,
// issues them one at a time with a 2-cycle in_valid, captures the result on
// the core's out_valid rising edge and returns it with the request tag.
// Optional macro ROOT_SCHED_BYPASS_EN resolves trivial requests locally.
module root_req_sched
  import root_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_radicand,
  input  logic [2:0]       req_degree,
  input  logic [TAG_W-1:0] req_tag,
  output logic             core_in_valid,
  output logic [9:0]       core_in_data_1,
  output logic [2:0]       core_in_data_2,
  input  logic             core_out_valid,
  input  logic [19:0]      core_out_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [19:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);
  localparam int EW = RAD_W + DEG_W + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_st_t        state, state_n;
  logic [EW-1:0]    f_rd;
  logic             f_full, f_empty;
  logic [CW-1:0]    f_cnt;
  logic             pop, ld_loc, ld_core, ld_res;
  logic             hd_vld;
  op_t              hd_op;
  logic [TAG_W-1:0] hd_tag, tag_q;
  logic [HC_W-1:0]  iss_cnt;
  logic             ov_q;
  logic             loc;
  logic [Q_W-1:0]   loc_data;

  assign req_ready = (f_cnt != CW'(FIFO_DEPTH));

  root_req_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && !f_full),
    .wdata ({req_radicand, req_degree, req_tag}),
    .pop   (pop),
    .rdata (f_rd),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  // decide whether the popped head is answered without the core
  always_comb begin
    loc      = (hd_op.deg == '0);
    loc_data = '0;
`ifdef ROOT_SCHED_BYPASS_EN
    if (hd_op.deg != '0) begin
      if (hd_op.deg == DEG_W'(1)) begin
        loc      = 1'b1;
        loc_data = {hd_op.rad, {FRAC_W{1'b0}}};
      end else if (hd_op.rad == '0) begin
        loc      = 1'b1;
        loc_data = '0;
      end else if (hd_op.rad == RAD_W'(1)) begin
        loc      = 1'b1;
        loc_data = Q_ONE;
      end
    end
`endif
  end

  // next state and one-cycle control strobes
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    ld_loc  = 1'b0;
    ld_core = 1'b0;
    ld_res  = 1'b0;
    case (state)
      S_IDLE: begin
        // head register gives the extra cycle before issue/local answer
        if (hd_vld) begin
          if (loc) ld_loc = 1'b1;
          else begin
            ld_core = 1'b1;
            state_n = S_ISSUE;
          end
        end else if (!f_empty && !rsp_valid && !core_out_valid) begin
          pop = 1'b1;
        end
      end
      S_ISSUE: if (iss_cnt == HC_W'(1)) state_n = S_WAIT;
      S_WAIT: begin
        // only the rising edge counts; the core holds out_valid 2 cycles
        if (core_out_valid && !ov_q) begin
          ld_res  = 1'b1;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: if (!core_out_valid) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // head, core operands and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q           <= 1'b0;
      hd_vld         <= 1'b0;
      hd_op          <= '0;
      hd_tag         <= '0;
      tag_q          <= '0;
      iss_cnt        <= '0;
      core_in_valid  <= 1'b0;
      core_in_data_1 <= '0;
      core_in_data_2 <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_tag        <= '0;
      rsp_err        <= 1'b0;
    end else begin
      ov_q <= core_out_valid;

      if (pop) begin
        hd_vld <= 1'b1;
        {hd_op.rad, hd_op.deg, hd_tag} <= f_rd;
      end else if (ld_loc || ld_core) begin
        hd_vld <= 1'b0;
      end

      // operands stay put until the next issue; the core reads degree live
      if (ld_core) begin
        core_in_data_1 <= hd_op.rad;
        core_in_data_2 <= hd_op.deg;
        tag_q          <= hd_tag;
        iss_cnt        <= HC_W'(HOLD_CNT);
        core_in_valid  <= 1'b1;
      end else if (state == S_ISSUE) begin
        iss_cnt        <= iss_cnt - 1'b1;
        core_in_valid  <= (iss_cnt > HC_W'(1));
      end

      // loads only happen into an empty register, so no load/consume clash
      if (ld_loc) begin
        rsp_valid <= 1'b1;
        rsp_data  <= loc_data;
        rsp_tag   <= hd_tag;
        rsp_err   <= (hd_op.deg == '0);
      end else if (ld_res) begin
        rsp_valid <= 1'b1;
        rsp_data  <= core_out_data;
        rsp_tag   <= tag_q;
        rsp_err   <= 1'b0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_root_req_sched.sv
// Bench for root_req_sched: behavioural root core, scoreboard of expected
// responses pushed at acceptance, monitor comparing on each response handshake.
module tb_root_req_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [9:0]  req_radicand;
  logic [2:0]  req_degree;
  logic [3:0]  req_tag;
  logic        core_in_valid;
  logic [9:0]  core_in_data_1;
  logic [2:0]  core_in_data_2;
  logic        core_out_valid;
  logic [19:0] core_out_data;
  logic        rsp_valid, rsp_ready;
  logic [19:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  logic [24:0] sb[$];

`ifdef ROOT_SCHED_BYPASS_EN
  localparam int EXP_BYP_ISSUES = 0;
`else
  localparam int EXP_BYP_ISSUES = 1;
`endif

  always #5 clk = ~clk;

  root_req_sched #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_degree(req_degree), .req_tag(req_tag),
    .core_in_valid(core_in_valid), .core_in_data_1(core_in_data_1),
    .core_in_data_2(core_in_data_2),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // hand-computed Q10.10 roots for the vectors used here
  function automatic logic [19:0] lut(input logic [9:0] r, input logic [2:0] d);
    if      (r == 10'd4  && d == 3'd2) return 20'h00800;
    else if (r == 10'd8  && d == 3'd3) return 20'h00800;
    else if (r == 10'd5  && d == 3'd1) return 20'h01400;
    else if (r == 10'd9  && d == 3'd2) return 20'h00C00;
    else if (r == 10'd27 && d == 3'd3) return 20'h00C00;
    else if (r == 10'd16 && d == 3'd4) return 20'h00800;
    else if (r == 10'd0  && d == 3'd3) return 20'h00000;
    else if (r == 10'd25 && d == 3'd2) return 20'h01400;
    else if (r == 10'd16 && d == 3'd2) return 20'h01000;
    return 20'hFFFFF;
  endfunction

  // core model: samples in 2nd in_valid cycle, computes, pulses out_valid 2 cycles
  logic [1:0] m_st;
  logic       in_cnt;
  logic [2:0] lat;
  logic [9:0] smp_rad;
  logic [2:0] smp_deg;
  int         n_issue;
  initial begin
    m_st <= 2'd0; in_cnt <= 1'b0; lat <= 3'd0; n_issue <= 0;
    smp_rad <= '0; smp_deg <= '0;
    core_out_valid <= 1'b0; core_out_data <= '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st <= 2'd0; in_cnt <= 1'b0; lat <= 3'd0;
        core_out_valid <= 1'b0; core_out_data <= '0;
      end else begin
        case (m_st)
          2'd0: if (core_in_valid) begin
                  if (in_cnt) begin
                    smp_rad <= core_in_data_1; smp_deg <= core_in_data_2;
                    in_cnt <= 1'b0; lat <= 3'd3; m_st <= 2'd1;
                    n_issue <= n_issue + 1;
                  end else in_cnt <= 1'b1;
                end else in_cnt <= 1'b0;
          2'd1: if (lat == 3'd0) begin
                  checks++;
                  if (core_in_data_1 !== smp_rad || core_in_data_2 !== smp_deg) begin
                    errors++;
                    $display("FAIL operand_stable: got rad=%0d deg=%0d, need rad=%0d deg=%0d",
                             core_in_data_1, core_in_data_2, smp_rad, smp_deg);
                  end
                  core_out_valid <= 1'b1;
                  core_out_data  <= lut(smp_rad, core_in_data_2);
                  m_st <= 2'd2;
                end else lat <= lat - 3'd1;
          2'd2: m_st <= 2'd3;
          default: begin core_out_valid <= 1'b0; m_st <= 2'd0; end
        endcase
      end
    end
  end

  // monitor: compare every consumed response against the scoreboard head
  initial begin
    logic [24:0] ex;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_extra: got err=%0b tag=%0d data=%h, need no response",
                   rsp_err, rsp_tag, rsp_data);
        end else begin
          ex = sb.pop_front();
          if ({rsp_err, rsp_tag, rsp_data} !== ex) begin
            errors++;
            $display("FAIL rsp: got err=%0b tag=%0d data=%h, need err=%0b tag=%0d data=%h",
                     rsp_err, rsp_tag, rsp_data, ex[24], ex[23:20], ex[19:0]);
          end
        end
      end
    end
  end

  // rsp_valid must be up one cycle after each core_out_valid rising edge
  initial begin
    logic ovp, pend;
    ovp = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin ovp = 1'b0; pend = 1'b0; end
      else begin
        if (pend) begin
          checks++;
          if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_after_core: got rsp_valid=0, need 1");
          end
        end
        pend = core_out_valid && !ovp;
        ovp  = core_out_valid;
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout, need completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic wait_accept(input logic [24:0] ex);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (ok) sb.push_back(ex);
    else begin
      errors++;
      $display("FAIL accept: got req_ready stuck low, need acceptance");
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic send(input logic [9:0] r, input logic [2:0] d, input logic [3:0] t,
                      input logic [19:0] e, input logic er);
    @(negedge clk);
    req_radicand = r; req_degree = d; req_tag = t; req_valid = 1'b1;
    wait_accept({er, t, e});
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d responses outstanding, need 0", nm, sb.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    logic [40:0] got, need;
    got  = {req_ready, core_in_valid, core_in_data_1, core_in_data_2,
            rsp_valid, rsp_data, rsp_tag, rsp_err};
    need = {1'b1, 40'd0};
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got outputs %h, need %h", nm, got, need);
    end
  endtask

  initial begin
    logic [4:0] pat;
    logic [2:0] rpat;
    int  n0;
    bit  blk;
    rst = 1'b1; req_valid = 1'b0; req_radicand = '0; req_degree = '0;
    req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // sqrt(4): in_valid timing, result 2.0
    send(10'd4, 3'd2, 4'd1, 20'h00800, 1'b0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); pat[i] = core_in_valid; end
    checks++;
    if (pat !== 5'b01100) begin
      errors++;
      $display("FAIL issue_timing: got in_valid pattern %b, need 01100", pat);
    end
    wait_drain("drain_sqrt4");

    // cbrt(8), tag 5; a second response would hit an empty scoreboard
    send(10'd8, 3'd3, 4'd5, 20'h00800, 1'b0);
    wait_drain("drain_cbrt8");
    repeat (10) @(negedge clk);

    // degree 0 error: no core access, rsp_valid 2 cycles after acceptance
    n0 = n_issue;
    send(10'd9, 3'd0, 4'd3, 20'h00000, 1'b1);
    for (int i = 0; i < 3; i++) begin @(negedge clk); rpat[i] = rsp_valid; end
    checks++;
    if (rpat !== 3'b100) begin
      errors++;
      $display("FAIL err_timing: got rsp_valid pattern %b, need 100", rpat);
    end
    wait_drain("drain_err");
    checks++;
    if (n_issue != n0) begin
      errors++;
      $display("FAIL err_no_core: got %0d core issues, need 0", n_issue - n0);
    end

    // degree 1: local with bypass, through the core otherwise
    n0 = n_issue;
    send(10'd5, 3'd1, 4'd2, 20'h01400, 1'b0);
    wait_drain("drain_deg1");
    checks++;
    if (n_issue - n0 != EXP_BYP_ISSUES) begin
      errors++;
      $display("FAIL deg1_issues: got %0d core issues, need %0d", n_issue - n0, EXP_BYP_ISSUES);
    end

    // back-pressure: fill the FIFO, then release and check order
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(10'd9,  3'd2, 4'd1, 20'h00C00, 1'b0);
    send(10'd27, 3'd3, 4'd2, 20'h00C00, 1'b0);
    send(10'd16, 3'd4, 4'd3, 20'h00800, 1'b0);
    send(10'd0,  3'd3, 4'd4, 20'h00000, 1'b0);
    send(10'd7,  3'd0, 4'd5, 20'h00000, 1'b1);
    repeat (30) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: got req_ready=%b, need 0", req_ready);
    end
    req_radicand = 10'd25; req_degree = 3'd2; req_tag = 4'd6; req_valid = 1'b1;
    blk = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (req_ready) blk = 1'b1; end
    checks++;
    if (blk) begin
      errors++;
      $display("FAIL full_hold: got req_ready=1 while full, need 0");
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_accept({1'b0, 4'd6, 20'h01400});
    wait_drain("drain_backpressure");

    // reset in the middle of WAIT
    send(10'd4, 3'd2, 4'd7, 20'h00800, 1'b0);
    blk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_st == 2'd1) begin blk = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!blk) begin
      errors++;
      $display("FAIL reach_wait: got no core busy state, need busy");
    end
    @(posedge clk); #2 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset("reset_mid_wait");
    @(posedge clk); #2 rst = 1'b0;
    n0 = n_issue;
    repeat (20) @(negedge clk);
    checks++;
    if (n_issue != n0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got issues=%0d rsp_valid=%b, need 0 and 0",
               n_issue - n0, rsp_valid);
    end
    send(10'd16, 3'd2, 4'd8, 20'h01000, 1'b0);
    wait_drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
